// File: rtl/pdp_mem_responder.sv
// Memory-side responder for the PDP multicycle processor: owns the main word
// array and services one read or write at a time through a wait-state sequence.
module pdp_mem_responder #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 12,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic                op_q;      // 1 = write, 0 = read
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                in_range;
  logic [IDX_W-1:0]    idx;
  logic                mem_we;

  assign in_range = 32'(addr_q) < 32'(DEPTH);
  assign idx      = addr_q[IDX_W-1:0];
  assign mem_we   = (state == S_ACCESS) && op_q && in_range;
  assign busy     = (state != S_IDLE);

  // The array is deliberately not reset; an async reset only stops mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_read && mem_write) begin
            err <= 1'b1;
          end else if (mem_read || mem_write) begin
            op_q    <= mem_write;
            addr_q  <= addr;
            wdata_q <= wdata;
            if (WAIT_CYCLES > 0) begin
              cnt   <= 4'(WAIT_CYCLES);
              state <= S_WAIT;
            end else begin
              state <= S_ACCESS;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            state <= S_ACCESS;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ACCESS: begin
          // ready/err are set here so they are visible during RESP.
          if (!op_q && in_range) begin
            rdata <= mem[idx];
          end
          ready <= 1'b1;
          err   <= !in_range;
          state <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
